// File: rtl/q_bank_scheduler.sv
// Sequences the per-action Q RAM banks: SCAN returns max Q/argmax for one state (done at cycle NACT+2), WRITE updates one bank (done at cycle 2).
// No backpressure: requests are taken only in IDLE and dropped otherwise; SCAN wins over a simultaneous WRITE.
module q_bank_scheduler #(
   parameter int DW   = 16,
   parameter int SW   = 4,
   parameter int NACT = 15
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start_scan,
   input  logic            start_write,
   input  logic [SW-1:0]   state_in,
   input  logic [3:0]      action_in,
   input  logic [DW-1:0]   q_in,
   input  logic [DW-1:0]   rd_data,
   output logic [NACT-1:0] bank_en,
   output logic            bank_we,
   output logic [SW-1:0]   bank_addr,
   output logic [DW-1:0]   bank_wdata,
   output logic            busy,
   output logic            done,
   output logic [DW-1:0]   max_q,
   output logic [3:0]      best_action
);

   typedef enum logic [2:0] {IDLE, SCAN_RD, SCAN_FLUSH, WRITE, DONE} state_t;

   localparam logic [3:0] LAST = 4'(NACT);

   state_t               st, st_nxt;
   logic [3:0]           cnt;
   logic [3:0]           wr_act;
   logic [SW-1:0]        addr_q;
   logic [DW-1:0]        wq;
   logic signed [DW-1:0] run_q;
   logic [3:0]           run_a;
   logic                 samp_vld;
   logic                 samp_first;
   logic                 take;
   logic [3:0]           samp_act;
   logic [3:0]           act_map;

   function automatic logic [NACT-1:0] onehot(input logic [3:0] a);
      logic [NACT-1:0] r;
      for (int k = 0; k < NACT; k++) r[k] = (a == 4'(k + 1));
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt  = st;
      bank_en = '0;
      bank_we = 1'b0;
      case (st)
         IDLE: begin
            if (start_scan)       st_nxt = SCAN_RD;
            else if (start_write) st_nxt = WRITE;
         end
         SCAN_RD: begin
            bank_en = onehot(cnt);
            if (cnt == LAST) st_nxt = SCAN_FLUSH;
         end
         SCAN_FLUSH: st_nxt = DONE;
         WRITE: begin
            bank_en = onehot(wr_act);
            bank_we = 1'b1;
            st_nxt  = DONE;
         end
         DONE:    st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   assign busy       = (st != IDLE);
   assign done       = (st == DONE);
   assign bank_addr  = addr_q;
   assign bank_wdata = wq;

   // Out-of-range actions fall back to action 1, matching the legacy enable decode.
   assign act_map = ((action_in == 4'd0) || (action_in > LAST)) ? 4'd1 : action_in;

   // rd_data lags the enable by one cycle, so the sample belongs to bank cnt-1.
   assign samp_vld   = ((st == SCAN_RD) && (cnt != 4'd1)) || (st == SCAN_FLUSH);
   assign samp_first = (st == SCAN_RD) && (cnt == 4'd2);
   assign samp_act   = (st == SCAN_FLUSH) ? LAST : (cnt - 4'd1);
   assign take       = samp_first || ($signed(rd_data) > run_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= 4'd1;
         wr_act      <= 4'd1;
         addr_q      <= '0;
         wq          <= '0;
         run_q       <= '0;
         run_a       <= 4'd1;
         max_q       <= '0;
         best_action <= 4'd1;
      end else begin
         if (st == IDLE) begin
            if (start_scan) begin
               addr_q <= state_in;
               cnt    <= 4'd1;
            end else if (start_write) begin
               addr_q <= state_in;
               wq     <= q_in;
               wr_act <= act_map;
            end
         end
         if (st == SCAN_RD) cnt <= cnt + 4'd1;
         if (samp_vld && take) begin
            run_q <= rd_data;
            run_a <= samp_act;
         end
         // Final bank's data arrives during the flush; publish together with done.
         if (st == SCAN_FLUSH) begin
            max_q       <= take ? rd_data : run_q;
            best_action <= take ? LAST : run_a;
         end
      end
   end

endmodule

// File: tb/tb_q_bank_scheduler.sv
// Directed bench for q_bank_scheduler with a registered-read bank model behind bank_en/bank_we.
module tb_q_bank_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_scan, start_write;
   logic [3:0]  state_in, action_in;
   logic [15:0] q_in, rd_data;
   logic [14:0] bank_en;
   logic        bank_we;
   logic [3:0]  bank_addr;
   logic [15:0] bank_wdata;
   logic        busy, done;
   logic [15:0] max_q;
   logic [3:0]  best_action;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   q_bank_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start_scan(start_scan), .start_write(start_write),
      .state_in(state_in), .action_in(action_in), .q_in(q_in), .rd_data(rd_data),
      .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr), .bank_wdata(bank_wdata),
      .busy(busy), .done(done), .max_q(max_q), .best_action(best_action)
   );

   // Initial bank contents per (action, state).
   function automatic logic [15:0] init_q(input int k, input int s);
      case (s)
         5:       return 16'(10 * k);
         3:       return ((k == 7) || (k == 12)) ? 16'hFFFD : 16'(-100 - k);
         9:       return 16'(-2 * k);
         default: return 16'(k);
      endcase
   endfunction

   logic [15:0] wmem [1:15][0:15];
   bit          wv   [1:15][0:15];

   always @(posedge clk) begin
      for (int k = 1; k <= 15; k++) begin
         if (bank_en[k-1]) begin
            if (bank_we) begin
               wmem[k][bank_addr] <= bank_wdata;
               wv[k][bank_addr]   <= 1'b1;
            end else begin
               rd_data <= wv[k][bank_addr] ? wmem[k][bank_addr] : init_q(k, int'(bank_addr));
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, act, exp);
      end
   endtask

   task automatic do_scan(input logic [3:0] st, input logic also_write,
                          input logic [15:0] eq, input logic [3:0] ea);
      @(negedge clk);
      start_scan  = 1'b1;
      start_write = also_write;
      state_in    = st;
      action_in   = 4'd2;
      q_in        = 16'h7FFF;
      @(negedge clk);
      start_scan  = 1'b0;
      start_write = 1'b0;
      for (int c = 1; c <= 15; c++) begin
         chk("walk_en", 32'(bank_en), 32'(15'(1) << (c - 1)));
         chk("walk_addr", 32'(bank_addr), 32'(st));
         chk("walk_we", 32'(bank_we), 32'd0);
         start_write = (c == 5);
         @(negedge clk);
      end
      start_write = 1'b0;
      chk("flush_en", 32'(bank_en), 32'd0);
      chk("flush_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("scan_done", 32'(done), 32'd1);
      chk("scan_busy", 32'(busy), 32'd1);
      chk("scan_maxq", 32'(max_q), 32'(eq));
      chk("scan_best", 32'(best_action), 32'(ea));
      @(negedge clk);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_we", 32'(bank_we), 32'd0);
   endtask

   task automatic do_write(input logic [3:0] st, input logic [3:0] a, input logic [15:0] q,
                           input logic [14:0] exp_en);
      @(negedge clk);
      start_write = 1'b1;
      state_in    = st;
      action_in   = a;
      q_in        = q;
      @(negedge clk);
      start_write = 1'b0;
      chk("wr_en", 32'(bank_en), 32'(exp_en));
      chk("wr_we", 32'(bank_we), 32'd1);
      chk("wr_addr", 32'(bank_addr), 32'(st));
      chk("wr_wdata", 32'(bank_wdata), 32'(q));
      chk("wr_done_early", 32'(done), 32'd0);
      @(negedge clk);
      chk("wr_done", 32'(done), 32'd1);
      chk("wr_en_done", 32'(bank_en), 32'd0);
      chk("wr_we_done", 32'(bank_we), 32'd0);
      @(negedge clk);
      chk("wr_idle", 32'(busy), 32'd0);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_scan  = 1'b0;
      start_write = 1'b0;
      state_in    = '0;
      action_in   = '0;
      q_in        = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // 1: idle after reset
      chk("rst_en", 32'(bank_en), 32'd0);
      chk("rst_we", 32'(bank_we), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_best", 32'(best_action), 32'd1);
      chk("rst_maxq", 32'(max_q), 32'd0);

      // 2: ascending Q, max at the last action
      do_scan(4'd5, 1'b0, 16'd150, 4'd15);
      // 3: negative values with a tie at -3
      do_scan(4'd3, 1'b0, 16'hFFFD, 4'd7);

      // 4: write, results held, rescan (with a simultaneous write request that must drop)
      do_write(4'd9, 4'd4, 16'h1234, 15'h0008);
      chk("hold_maxq", 32'(max_q), 32'hFFFD);
      chk("hold_best", 32'(best_action), 32'd7);
      do_scan(4'd9, 1'b1, 16'h1234, 4'd4);

      // 5: action 0 maps to bank 1
      do_write(4'd9, 4'd0, 16'h5000, 15'h0001);
      do_scan(4'd9, 1'b0, 16'h5000, 4'd1);

      // 6: reset in the middle of a scan
      @(negedge clk);
      start_scan = 1'b1;
      state_in   = 4'd5;
      @(negedge clk);
      start_scan = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_en", 32'(bank_en), 32'h0080);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_en", 32'(bank_en), 32'd0);
      chk("mid_rst_we", 32'(bank_we), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_maxq", 32'(max_q), 32'd0);
      chk("mid_rst_best", 32'(best_action), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      do_scan(4'd5, 1'b0, 16'd150, 4'd15);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
